// File: rtl/adt7420_i2c_target.sv
// I2C target that mimics the ADT7420 register map, oversampling SCL/SDA on clk.
// Define ADT7420_I2C_TARGET_FILTER_EN to add a 4-sample glitch filter on SCL/SDA.
module adt7420_i2c_target #(
    parameter logic [6:0] ADDR      = 7'h48,
    parameter logic [7:0] DEVICE_ID = 8'hCB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_data,
    output logic [7:0]  config_reg,
    output logic        busy,
    output logic        addr_hit,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  scl_sync;
    logic [1:0]  sda_sync;
    logic        scl_cur;
    logic        sda_cur;
    logic        scl_prev;
    logic        sda_prev;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;

    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  byte_in;
    logic [7:0]  rd_byte;
    logic [3:0]  ptr;
    logic [15:0] snapshot;
    logic        rw;
    logic        rd_ack;
    logic        last_bit;
    logic        addr_match;
    logic        sda_oe_nxt;
    logic        addr_hit_nxt;

    // Synchronizers reset to the idle bus level so reset release creates no events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef ADT7420_I2C_TARGET_FILTER_EN
    logic [2:0] scl_hist;
    logic [2:0] sda_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
        end
    end

    // The edge register doubles as the held filter value until 4 samples agree.
    always_comb begin
        scl_cur = scl_prev;
        sda_cur = sda_prev;
        if (scl_hist == {3{scl_sync[1]}}) scl_cur = scl_sync[1];
        if (sda_hist == {3{sda_sync[1]}}) sda_cur = sda_sync[1];
    end
`else
    assign scl_cur = scl_sync[1];
    assign sda_cur = sda_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_cur;
            sda_prev <= sda_cur;
        end
    end

    assign scl_rise   = scl_cur & ~scl_prev;
    assign scl_fall   = ~scl_cur & scl_prev;
    assign start_det  = scl_cur & scl_prev & sda_prev & ~sda_cur;
    assign stop_det   = scl_cur & scl_prev & ~sda_prev & sda_cur;

    assign byte_in    = {shreg[6:0], sda_cur};
    assign last_bit   = scl_rise && (bit_cnt == 3'd7);
    assign addr_match = (byte_in[7:1] == ADDR);
    assign state_dbg  = state;

    always_comb begin
        case (ptr)
            4'h0:    rd_byte = snapshot[15:8];
            4'h1:    rd_byte = snapshot[7:0];
            4'h2:    rd_byte = 8'h80;
            4'h3:    rd_byte = config_reg;
            4'hB:    rd_byte = DEVICE_ID;
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // In the target ACK states sda_oe itself marks whether the ACK low has begun.
    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = S_IDLE;
        end else if (start_det) begin
            state_nxt = S_ADDR;
        end else begin
            case (state)
                S_IDLE:      state_nxt = S_IDLE;
                S_ADDR:      if (last_bit) state_nxt = addr_match ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK:  if (scl_fall && sda_oe) state_nxt = rw ? S_RDATA : S_PTR;
                S_PTR:       if (last_bit) state_nxt = S_PTR_ACK;
                S_PTR_ACK:   if (scl_fall && sda_oe) state_nxt = S_WDATA;
                S_WDATA:     if (last_bit) state_nxt = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_fall && sda_oe) state_nxt = S_WDATA;
                S_RDATA:     if (last_bit) state_nxt = S_RDATA_ACK;
                S_RDATA_ACK: begin
                    if (scl_rise && sda_cur)     state_nxt = S_IDLE;
                    else if (scl_fall && rd_ack) state_nxt = S_RDATA;
                end
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sda_oe_nxt   = 1'b0;
        addr_hit_nxt = 1'b0;
        if (!(start_det || stop_det)) begin
            case (state)
                S_ADDR: addr_hit_nxt = last_bit && addr_match;
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    sda_oe_nxt = sda_oe;
                    if (scl_fall) begin
                        if (!sda_oe)
                            sda_oe_nxt = 1'b1;
                        else if (state == S_ADDR_ACK && rw)
                            sda_oe_nxt = ~rd_byte[7];
                        else
                            sda_oe_nxt = 1'b0;
                    end
                end
                S_RDATA: begin
                    sda_oe_nxt = sda_oe;
                    if (scl_fall && bit_cnt != 3'd0) sda_oe_nxt = ~shreg[~bit_cnt];
                end
                S_RDATA_ACK: begin
                    sda_oe_nxt = sda_oe;
                    if (scl_fall) sda_oe_nxt = rd_ack & ~rd_byte[7];
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_oe     <= 1'b0;
            addr_hit   <= 1'b0;
            busy       <= 1'b0;
            config_reg <= 8'h00;
            ptr        <= 4'h0;
            snapshot   <= 16'h0000;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            rw         <= 1'b0;
            rd_ack     <= 1'b0;
        end else begin
            sda_oe   <= sda_oe_nxt;
            addr_hit <= addr_hit_nxt;
            if (addr_hit_nxt)
                busy <= 1'b1;
            else if (stop_det || (state == S_ADDR && last_bit && !addr_match))
                busy <= 1'b0;

            if (start_det || stop_det) begin
                bit_cnt <= 3'd0;
                rd_ack  <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                // Snapshot only on a read match keeps MSB/LSB coherent.
                                if (state == S_ADDR && addr_match) begin
                                    rw <= sda_cur;
                                    if (sda_cur) snapshot <= temp_data;
                                end
                                if (state == S_PTR) ptr <= byte_in[3:0];
                                if (state == S_WDATA && ptr == 4'h3) config_reg <= byte_in;
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall && sda_oe) begin
                            bit_cnt <= 3'd0;
                            if (state == S_ADDR_ACK)  shreg <= rd_byte;
                            if (state == S_WDATA_ACK) ptr   <= ptr + 4'd1;
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise && !sda_cur) begin
                            ptr    <= ptr + 4'd1;
                            rd_ack <= 1'b1;
                        end else if (scl_fall && rd_ack) begin
                            shreg   <= rd_byte;
                            bit_cnt <= 3'd0;
                            rd_ack  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adt7420_i2c_target.sv
// Bench for adt7420_i2c_target: bit-banged I2C master, vector table, hand sequences, random traffic.
module tb_adt7420_i2c_target;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic [15:0] temp_data = 16'h0000;
    logic        sda_oe;
    logic [7:0]  config_reg;
    logic        busy;
    logic        addr_hit;
    logic [3:0]  state_dbg;

    int total = 0;
    int bad = 0;
    int hit_cnt = 0;
    int oe_cnt = 0;

    always #5 clk = ~clk;

    // Open-drain bus: the line is low when either side pulls it low.
    assign sda_bus = sda_m & ~sda_oe;

    adt7420_i2c_target dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .temp_data  (temp_data),
        .config_reg (config_reg),
        .busy       (busy),
        .addr_hit   (addr_hit),
        .state_dbg  (state_dbg)
    );

    always @(posedge clk) begin
        if (addr_hit) hit_cnt <= hit_cnt + 1;
        if (sda_oe)   oe_cnt  <= oe_cnt + 1;
    end

    typedef struct {
        logic        rd;
        logic [3:0]  ptr;
        logic [7:0]  wdata;
        logic [15:0] temp;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_cfg;
    } vec_t;

    vec_t        vecs [13];
    logic [7:0]  exp_q [$];

    logic [7:0]  m_cfg;
    logic [3:0]  m_ptr;
    logic [15:0] m_snap;

    logic        ack_ok;
    logic        b;
    logic [7:0]  rd;
    logic [3:0]  nib;
    logic [7:0]  pb;
    logic [7:0]  wd;
    int          kind;
    int          n;
    int          hit_before;
    int          oe_before;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            sda_m = 1'b1; cyc(5);
            scl_m = 1'b1; cyc(10);
        end
        sda_m = 1'b0; cyc(10);
        scl_m = 1'b0; cyc(5);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; cyc(5);
        scl_m = 1'b1; cyc(10);
        sda_m = 1'b1; cyc(10);
    endtask

    task automatic write_bit(input logic v);
        sda_m = v;    cyc(5);
        scl_m = 1'b1; cyc(10);
        scl_m = 1'b0; cyc(5);
    endtask

    task automatic read_bit(output logic v);
        sda_m = 1'b1; cyc(5);
        scl_m = 1'b1; cyc(5);
        v = sda_bus;  cyc(5);
        scl_m = 1'b0; cyc(5);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ok);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        ok = ~a;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic master_ack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            d[i] = v;
        end
        write_bit(~master_ack);
    endtask

    task automatic pulse_reset();
        rst = 1'b1; cyc(3);
        rst = 1'b0; cyc(3);
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] p);
        case (p)
            4'h0:    return m_snap[15:8];
            4'h1:    return m_snap[7:0];
            4'h2:    return 8'h80;
            4'h3:    return m_cfg;
            4'hB:    return 8'hCB;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{1'b0, 4'h3, 8'hA5, 16'h0000, 8'h00, 8'hA5};
        vecs[1]  = '{1'b1, 4'h3, 8'h00, 16'h0000, 8'hA5, 8'hA5};
        vecs[2]  = '{1'b1, 4'h0, 8'h00, 16'h0C80, 8'h0C, 8'hA5};
        vecs[3]  = '{1'b1, 4'h1, 8'h00, 16'h0C80, 8'h80, 8'hA5};
        vecs[4]  = '{1'b1, 4'h2, 8'h00, 16'h0C80, 8'h80, 8'hA5};
        vecs[5]  = '{1'b1, 4'hB, 8'h00, 16'h0C80, 8'hCB, 8'hA5};
        vecs[6]  = '{1'b0, 4'h0, 8'h55, 16'h0C80, 8'h00, 8'hA5};
        vecs[7]  = '{1'b1, 4'h0, 8'h00, 16'h1234, 8'h12, 8'hA5};
        vecs[8]  = '{1'b1, 4'h7, 8'h00, 16'h1234, 8'h00, 8'hA5};
        vecs[9]  = '{1'b0, 4'h3, 8'h3C, 16'h1234, 8'h00, 8'h3C};
        vecs[10] = '{1'b1, 4'h3, 8'h00, 16'h1234, 8'h3C, 8'h3C};
        vecs[11] = '{1'b1, 4'hF, 8'h00, 16'h1234, 8'h00, 8'h3C};
        vecs[12] = '{1'b1, 4'h1, 8'h00, 16'hBEEF, 8'hEF, 8'h3C};

        cyc(4);
        rst = 1'b0;
        cyc(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_addr_hit", addr_hit, 0);
        check("rst_config", config_reg, 8'h00);
        check("rst_state", state_dbg, 0);

        // Write config 0xA5 and watch busy across STOP.
        hit_before = hit_cnt;
        bus_start();
        write_byte(8'h90, ack_ok); check("w_addr_ack", ack_ok, 1);
        check("w_busy_after_match", busy, 1);
        write_byte(8'h03, ack_ok); check("w_ptr_ack", ack_ok, 1);
        write_byte(8'hA5, ack_ok); check("w_data_ack", ack_ok, 1);
        check("w_config", config_reg, 8'hA5);
        check("w_busy_before_stop", busy, 1);
        bus_stop();
        check("w_busy_after_stop", busy, 0);
        check("w_hit_pulse", hit_cnt - hit_before, 1);

        // Repeated-start read of the temperature word, master ACK then NACK.
        temp_data = 16'h0C80;
        bus_start();
        write_byte(8'h90, ack_ok); check("r_addr_w_ack", ack_ok, 1);
        write_byte(8'h00, ack_ok); check("r_ptr_ack", ack_ok, 1);
        bus_start();
        write_byte(8'h91, ack_ok); check("r_addr_r_ack", ack_ok, 1);
        read_byte(rd, 1'b1); check("r_msb", rd, 8'h0C);
        read_byte(rd, 1'b0); check("r_lsb", rd, 8'h80);
        check("r_idle_after_nack", state_dbg, 0);
        check("r_sda_released", sda_oe, 0);
        bus_stop();

        // Device ID, then pointer wrap 0xF -> 0x0.
        bus_start();
        write_byte(8'h90, ack_ok); write_byte(8'h0B, ack_ok);
        bus_start();
        write_byte(8'h91, ack_ok);
        read_byte(rd, 1'b0); check("id_read", rd, 8'hCB);
        bus_stop();
        bus_start();
        write_byte(8'h90, ack_ok); write_byte(8'h0F, ack_ok);
        bus_start();
        write_byte(8'h91, ack_ok);
        read_byte(rd, 1'b1); check("wrap_ptr_f", rd, 8'h00);
        read_byte(rd, 1'b0); check("wrap_ptr_0", rd, 8'h0C);
        bus_stop();

        // Foreign address is ignored entirely, the next own transaction is ACKed.
        hit_before = hit_cnt;
        oe_before  = oe_cnt;
        bus_start();
        write_byte(8'h92, ack_ok); check("other_addr_nack", ack_ok, 0);
        write_byte(8'h03, ack_ok); check("other_addr_data_nack", ack_ok, 0);
        bus_stop();
        check("other_addr_no_hit", hit_cnt - hit_before, 0);
        check("other_addr_no_oe", oe_cnt - oe_before, 0);
        check("other_addr_not_busy", busy, 0);
        bus_start();
        write_byte(8'h90, ack_ok); check("own_addr_after_other", ack_ok, 1);
        bus_stop();
        check("own_addr_hit", hit_cnt - hit_before, 1);

        // temp_data changing mid-read must not tear the word.
        temp_data = 16'h0C80;
        bus_start();
        write_byte(8'h90, ack_ok); write_byte(8'h00, ack_ok);
        bus_start();
        write_byte(8'h91, ack_ok);
        read_byte(rd, 1'b1); check("coh_msb", rd, 8'h0C);
        temp_data = 16'h1234;
        read_byte(rd, 1'b0); check("coh_lsb", rd, 8'h80);
        bus_stop();

        // Reset in the low phase of read bit 3 (config 0x81, so bit 3 pulls low).
        bus_start();
        write_byte(8'h90, ack_ok); write_byte(8'h03, ack_ok);
        write_byte(8'h81, ack_ok); check("mid_cfg_write", config_reg, 8'h81);
        bus_start();
        write_byte(8'h90, ack_ok); write_byte(8'h03, ack_ok);
        bus_start();
        write_byte(8'h91, ack_ok);
        for (int i = 7; i >= 4; i--) begin
            read_bit(b);
            rd[i] = b;
        end
        check("mid_high_nibble", rd[7:4], 4'h8);
        check("mid_bit3_driven", sda_oe, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_config", config_reg, 8'h00);
        check("mid_rst_busy", busy, 0);
        cyc(3);
        rst = 1'b0;
        cyc(3);
        bus_stop();
        bus_start();
        write_byte(8'h90, ack_ok); check("mid_post_rst_ack", ack_ok, 1);
        bus_stop();

        // Vector table, each entry its own transaction.
        pulse_reset();
        for (int i = 0; i < 13; i++) begin
            temp_data = vecs[i].temp;
            bus_start();
            write_byte(8'h90, ack_ok); check($sformatf("vec%0d_addr_ack", i), ack_ok, 1);
            write_byte({4'hA, vecs[i].ptr}, ack_ok); check($sformatf("vec%0d_ptr_ack", i), ack_ok, 1);
            if (vecs[i].rd) begin
                bus_start();
                write_byte(8'h91, ack_ok); check($sformatf("vec%0d_raddr_ack", i), ack_ok, 1);
                read_byte(rd, 1'b0);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            end else begin
                write_byte(vecs[i].wdata, ack_ok); check($sformatf("vec%0d_wdata_ack", i), ack_ok, 1);
            end
            bus_stop();
            check($sformatf("vec%0d_config", i), config_reg, vecs[i].exp_cfg);
        end

        // Random traffic against the register-map model.
        pulse_reset();
        m_cfg  = 8'h00;
        m_ptr  = 4'h0;
        m_snap = 16'h0000;
        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 2);
            pb   = 8'($urandom_range(0, 255));
            nib  = ($urandom_range(0, 1) == 1) ? 4'h3 : pb[3:0];
            pb   = {pb[7:4], nib};
            bus_start();
            if (kind == 0) begin
                write_byte(8'h90, ack_ok); check("rnd_w_addr_ack", ack_ok, 1);
                write_byte(pb, ack_ok); check("rnd_w_ptr_ack", ack_ok, 1);
                m_ptr = pb[3:0];
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) begin
                    wd = 8'($urandom_range(0, 255));
                    write_byte(wd, ack_ok); check("rnd_w_data_ack", ack_ok, 1);
                    if (m_ptr == 4'h3) m_cfg = wd;
                    m_ptr = m_ptr + 4'd1;
                end
                bus_stop();
                check("rnd_config", config_reg, m_cfg);
            end else begin
                if (kind == 1) begin
                    write_byte(8'h90, ack_ok); check("rnd_r_addr_w_ack", ack_ok, 1);
                    write_byte(pb, ack_ok); check("rnd_r_ptr_ack", ack_ok, 1);
                    m_ptr = pb[3:0];
                    bus_start();
                end
                temp_data = 16'($urandom_range(0, 65535));
                m_snap = temp_data;
                write_byte(8'h91, ack_ok); check("rnd_r_addr_ack", ack_ok, 1);
                n = $urandom_range(1, 4);
                for (int j = 0; j < n; j++) begin
                    exp_q.push_back(m_read(m_ptr));
                    read_byte(rd, (j < n - 1));
                    temp_data = 16'($urandom_range(0, 65535));
                    check("rnd_rdata", rd, exp_q.pop_front());
                    if (j < n - 1) m_ptr = m_ptr + 4'd1;
                end
                bus_stop();
            end
            check("rnd_busy_after_stop", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
